// File: rtl/seq_magnitude_comparator_pkg.sv
// ----------------------------------------------------------------------------
// seq_magnitude_comparator_pkg
//
// Shared definitions for the sequential comparator family: FSM state
// encoding, sticky-decision encoding, the packed result flags and small
// helpers used to size and decode them.
//
// No ports (package).
// ----------------------------------------------------------------------------
package seq_magnitude_comparator_pkg;

    // FSM states shared by sequential comparators built on a slice comparator.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompare = 2'd1,
        StDone    = 2'd2
    } cmp_state_e;

    // Sticky decision: the first unequal slice seen during a full scan.
    typedef enum logic [1:0] {
        DecNone = 2'd0,
        DecGt   = 2'd1,
        DecLt   = 2'd2
    } cmp_dec_e;

    // Final result flags; exactly one-hot once a comparison has completed.
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    localparam cmp_result_t ResultClr = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
    localparam cmp_result_t ResultGt  = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
    localparam cmp_result_t ResultEq  = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    localparam cmp_result_t ResultLt  = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};

    // Slice index width; a single-slice operand still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    // No decision recorded means every slice matched.
    function automatic cmp_result_t dec_to_result(input cmp_dec_e dec);
        cmp_result_t res;
        unique case (dec)
            DecGt:   res = ResultGt;
            DecLt:   res = ResultLt;
            default: res = ResultEq;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparator_2bit.sv
// ----------------------------------------------------------------------------
// comparator_2bit
//
// Combinational magnitude comparator for two 2-bit unsigned values.
//
// Ports:
//   a_i  [1:0]  operand a
//   b_i  [1:0]  operand b
//   gt_o        a > b
//   eq_o        a == b
//   lt_o        a < b
// ----------------------------------------------------------------------------
module comparator_2bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// MSB-first sequential magnitude comparator for WIDTH-bit unsigned operands.
// Operands are latched on start and resolved one 2-bit slice per clock
// through a single comparator_2bit. EARLY_EXIT=1 stops at the first unequal
// slice; EARLY_EXIT=0 always scans every slice for constant latency.
//
// Ports:
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   start             comparison request, accepted in IDLE or DONE
//   A, B   [WIDTH-1:0] unsigned operands, captured on acceptance
//   busy              high while comparing
//   done              one-cycle completion pulse
//   A_gt_B            registered result A > B
//   A_eq_B            registered result A == B
//   A_lt_B            registered result A < B
// ----------------------------------------------------------------------------
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    import seq_magnitude_comparator_pkg::*;

    localparam int unsigned NSLICE = WIDTH / 2;
    localparam int unsigned IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] IdxMax = IDXW'(NSLICE - 1);

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    cmp_dec_e         dec_q, dec_d;
    cmp_result_t      res_q, res_d;

    logic [1:0] a_slice;
    logic [1:0] b_slice;
    logic       slice_gt;
    logic       slice_eq;
    logic       slice_lt;
    logic       accept;
    cmp_dec_e   dec_upd;

    // Slice mux on the latched operands; slice idx covers bits [2*idx+1:2*idx].
    assign a_slice = a_q[{idx_q, 1'b0} +: 2];
    assign b_slice = b_q[{idx_q, 1'b0} +: 2];

    comparator_2bit u_cmp (
        .a_i  (a_slice),
        .b_i  (b_slice),
        .gt_o (slice_gt),
        .eq_o (slice_eq),
        .lt_o (slice_lt)
    );

    // A new request is taken in IDLE and also in DONE for back-to-back use.
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    // Only the first unequal slice may set the sticky decision.
    always_comb begin
        dec_upd = dec_q;
        if ((dec_q == DecNone) && !slice_eq) begin
            dec_upd = slice_gt ? DecGt : DecLt;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        res_d   = res_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end

            StCompare: begin
                busy = 1'b1;
                if (EARLY_EXIT) begin
                    if (!slice_eq) begin
                        res_d   = '{gt: slice_gt, eq: 1'b0, lt: slice_lt};
                        state_d = StDone;
                    end else if (idx_q == '0) begin
                        res_d   = ResultEq;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    dec_d = dec_upd;
                    if (idx_q == '0) begin
                        res_d   = dec_to_result(dec_upd);
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            a_d     = A;
            b_d     = B;
            idx_d   = IdxMax;
            dec_d   = DecNone;
            state_d = StCompare;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            dec_q   <= DecNone;
            res_q   <= ResultClr;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
        end
    end

    assign A_gt_B = res_q.gt;
    assign A_eq_B = res_q.eq;
    assign A_lt_B = res_q.lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: dut 0 uses EARLY_EXIT=1, dut 1 uses EARLY_EXIT=0.
module tb_seq_magnitude_comparator;

    localparam int unsigned W      = 8;
    localparam int unsigned NSLICE = W / 2;

    typedef struct {
        logic [2:0]  flags;   // {gt, eq, lt}
        int unsigned cyc;     // edge count at which done is expected
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          start_s;
    logic [1:0][W-1:0]   a_s;
    logic [1:0][W-1:0]   b_s;
    logic [1:0]          busy_s, done_s, gt_s, eq_s, lt_s;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [2:0] hold[2];
    bit         hold_v[2];

    seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s[0]),
        .A      (a_s[0]),
        .B      (b_s[0]),
        .busy   (busy_s[0]),
        .done   (done_s[0]),
        .A_gt_B (gt_s[0]),
        .A_eq_B (eq_s[0]),
        .A_lt_B (lt_s[0])
    );

    seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s[1]),
        .A      (a_s[1]),
        .B      (b_s[1]),
        .busy   (busy_s[1]),
        .done   (done_s[1]),
        .A_gt_B (gt_s[1]),
        .A_eq_B (eq_s[1]),
        .A_lt_B (lt_s[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // Reference: result from plain unsigned compare; latency from the first
    // differing 2-bit slice counted from the MSB end.
    function automatic exp_t model(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int unsigned e0);
        exp_t        e;
        int unsigned lat;
        int unsigned sa, sb;
        lat = NSLICE + 1;
        if (d == 0) begin
            for (int m = 0; m < NSLICE; m++) begin
                sa = (int'(a) >> (2 * (NSLICE - 1 - m))) % 4;
                sb = (int'(b) >> (2 * (NSLICE - 1 - m))) % 4;
                if (sa != sb) begin
                    lat = 2 + m;
                    break;
                end
            end
        end
        e.flags = {a > b, a == b, a < b};
        e.cyc   = e0 + lat - 1;
        return e;
    endfunction

    task automatic mon(input int d);
        exp_t       e;
        logic [2:0] f;
        int         qs;
        if (rst) begin
            // Flags read zero once reset has been sampled; pending work is dropped.
            hold[d]   = 3'b000;
            hold_v[d] = 1'b1;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        f  = {gt_s[d], eq_s[d], lt_s[d]};
        qs = (d == 0) ? q0.size() : q1.size();
        if (done_s[d] === 1'b1) begin
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, expected 0", d, edge_cnt);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk($sformatf("result_flags dut%0d", d), 32'(f), 32'(e.flags));
                chk($sformatf("done_cycle dut%0d", d), edge_cnt, e.cyc);
                hold[d]   = e.flags;
                hold_v[d] = 1'b1;
            end
        end else if (hold_v[d]) begin
            chk($sformatf("flags_hold dut%0d", d), 32'(f), 32'(hold[d]));
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start_s[d] = 1'b1;
        a_s[d]     = a;
        b_s[d]     = b;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        e = model(d, a, b, edge_cnt);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Returns just after the edge that enters DONE (bounded).
    task automatic wait_done(input int d);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done_s[d] !== 1'b1 && n < 20);
        if (done_s[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done dut%0d: done=%b after %0d cycles, expected 1", d, done_s[d], n);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_s = 2'b11;
        a_s[0]  = 8'hC5; b_s[0] = 8'h35;
        a_s[1]  = 8'h00; b_s[1] = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        start_s = 2'b00;

        // Reset state, start during reset ignored
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_busy dut%0d", d), 32'(busy_s[d]), 0);
            chk($sformatf("reset_done dut%0d", d), 32'(done_s[d]), 0);
            chk($sformatf("reset_flags dut%0d", d), 32'({gt_s[d], eq_s[d], lt_s[d]}), 0);
        end
        @(negedge clk);
        chk("reset_start_ignored busy0", 32'(busy_s[0]), 0);
        chk("reset_start_ignored busy1", 32'(busy_s[1]), 0);
        @(posedge clk);
        #1;

        // Early exit on the MSB slice
        issue(0, 8'hC5, 8'h35);
        @(negedge clk);
        chk("msb_busy_cycle1", 32'(busy_s[0]), 1);
        @(negedge clk);
        chk("msb_busy_cycle2", 32'(busy_s[0]), 0);
        chk("msb_done_cycle2", 32'(done_s[0]), 1);
        @(posedge clk);
        #1;

        // Equal operands, then flags hold over idle cycles
        issue(0, 8'hA6, 8'hA6);
        wait_done(0);
        repeat (3) begin @(posedge clk); #1; end

        // LSB difference; operand changes and start pulses while busy are ignored
        issue(0, 8'h12, 8'h13);
        for (int i = 0; i < 4; i++) begin
            a_s[0]     = W'($urandom);
            b_s[0]     = W'($urandom);
            start_s[0] = 1'b1;
            @(posedge clk);
            #1;
        end
        start_s[0] = 1'b0;
        chk("lsb_done_cycle5", 32'(done_s[0]), 1);
        @(posedge clk);
        #1;

        // Reset abort in cycle 2, then a normal comparison
        issue(0, 8'h12, 8'h13);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_s[0]), 0);
        chk("abort_done", 32'(done_s[0]), 0);
        @(posedge clk);
        #1;
        issue(0, 8'h40, 8'h41);
        wait_done(0);
        @(posedge clk);
        #1;

        // Full scan with back-to-back start accepted in DONE
        issue(1, 8'hC5, 8'h35);
        wait_done(1);
        issue(1, 8'h00, 8'h01);
        wait_done(1);
        @(posedge clk);
        #1;

        // Randomized operands, biased towards shared upper slices
        for (int i = 0; i < 60; i++) begin
            int         d;
            int         k;
            logic [W-1:0] a, b;
            d = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 3));
            a = W'($urandom);
            case (k)
                0:       b = W'($urandom);
                1:       b = a;
                2:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = {a[W-1:2], 2'($urandom)};
            endcase
            issue(d, a, b);
            wait_done(d);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("drain dut0", q0.size(), 0);
        chk("drain dut1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Sequential, MSB-first magnitude comparator for WIDTH-bit unsigned operands. It splits the operands into 2-bit slices and resolves them one slice per clock through an instantiated `comparator_2bit`, consuming that comparator's gt/eq/lt outputs. It trades latency for area, extending the 2-bit comparator to arbitrary even widths behind a start/done handshake.

## Interface
- `WIDTH`, default 8: operand width; must be even and ≥ 2. `NSLICE = WIDTH/2`.
- `EARLY_EXIT`, default 1: 1 = finish at the first unequal slice; 0 = always scan all NSLICE slices (constant latency).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a comparison; sampled on the rising edge.
- `A` input WIDTH: operand A, unsigned; captured when `start` is accepted.
- `B` input WIDTH: operand B, unsigned; captured when `start` is accepted.
- `busy` output 1: high while in COMPARE.
- `done` output 1: one-cycle pulse; the result is valid from this cycle on.
- `A_gt_B` output 1: registered result, A > B.
- `A_eq_B` output 1: registered result, A == B.
- `A_lt_B` output 1: registered result, A < B.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE:
  - `start=1` → latch A and B into internal registers, set slice index `idx = NSLICE-1`, clear the sticky-decision register, go to COMPARE.
  - `start=0` → stay in IDLE.
- COMPARE, each cycle:
  - Drive the `comparator_2bit` with slice `idx` (bits `[2*idx+1 : 2*idx]`) of the latched operands.
  - EARLY_EXIT=1:
    - Slice unequal → capture that slice's gt/lt as the final result, go to DONE.
    - Slice equal and `idx == 0` → final result is eq, go to DONE.
    - Slice equal and `idx > 0` → `idx` decrements.
  - EARLY_EXIT=0:
    - The first unequal slice sets the sticky decision; later slices are ignored.
    - At `idx == 0`, the result is the sticky decision, or eq if none was set. Go to DONE.
- DONE:
  - `done=1` for exactly one cycle.
  - `start=1` in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Result flags update only on the COMPARE→DONE transition. They are exactly one-hot after the first completion and hold until the next completion.
- `start` is ignored while in COMPARE.
- Changes on A/B after acceptance have no effect on the running comparison.
- Arithmetic is unsigned; no sign handling. `idx` is `$clog2(NSLICE)` bits wide, minimum 1.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `A_gt_B=0`, `A_eq_B=0`, `A_lt_B=0`.
- Cycle numbering: `start` is sampled at edge 0.
  - COMPARE begins in cycle 1.
  - Slice m (counting from the MSB slice, m=0) is evaluated in cycle 1+m.
- Latency, EARLY_EXIT=1:
  - First unequal slice is m → `done` in cycle 2+m.
  - Operands equal → `done` in cycle NSLICE+1.
- Latency, EARLY_EXIT=0: `done` is always in cycle NSLICE+1.
- `busy` is high in cycles 1 through the last compare cycle. It is low in DONE and IDLE.
- Throughput (back-to-back start accepted in DONE): one comparison per (latency) cycles.
- `rst` mid-operation, in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - No `done` is produced for the aborted comparison.
- `rst` and `start` high together → reset wins; `start` is dropped.

## Structure
- State encodings (IDLE/COMPARE/DONE) live in the shared comparator header, so sibling sequential comparators reuse them.
- One sub-module: the existing `comparator_2bit`, instantiated once and fed by a slice mux on the latched operands.
- The FSM, index counter and result registers are local to this module.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Reset: hold `rst` 2 cycles → `busy=0`, `done=0`, all three flags 0; `start=1` held during reset is ignored.
- Early exit on MSB slice: A=8'hC5, B=8'h35, pulse `start` → `done` in cycle 2, `A_gt_B=1`, the other flags 0, `busy` high only in cycle 1.
- Equal operands: A=B=8'hA6 → `done` in cycle 5, `A_eq_B=1`; flags hold after `done` until the next completion.
- LSB-slice difference: A=8'h12, B=8'h13 → `done` in cycle 5, `A_lt_B=1`. During cycles 1–4, toggling A/B and pulsing `start` changes nothing.
- Reset abort: A=8'h12, B=8'h13, assert `rst` in cycle 2 → no `done`, IDLE next cycle. A new `start` afterwards completes normally.
- EARLY_EXIT=0 with back-to-back starts: A=8'hC5, B=8'h35 → `done` in cycle 5, `A_gt_B=1`. Assert `start` in the DONE cycle with A=8'h00, B=8'h01 → second `done` 5 cycles later, `A_lt_B=1`.
